// File: rtl/multi_divi_pkg.sv
// Shared constants, FSM encoding and width helpers for the multiply/divide metric evaluator.
package multi_divi_pkg;

  localparam logic [1:0] ST_GEN  = 2'd2;
  localparam logic [1:0] ST_GEN2 = 2'd3;

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_RUN,
    EV_FLUSH,
    EV_DONE
  } eval_state_e;

  function automatic int calc_j_width(input int j);
    return $clog2(j) + 1;
  endfunction

  function automatic int calc_a_width(input int a);
    return $clog2(a) + 1;
  endfunction

  // Signed metric range for an mw-bit two's-complement accumulator
  function automatic longint metric_max(input int mw);
    return (longint'(1) <<< (mw - 1)) - 1;
  endfunction

  function automatic longint metric_min(input int mw);
    return -(longint'(1) <<< (mw - 1));
  endfunction

endpackage

// File: rtl/multi_divi_llr_rf.sv
// J x A signed log-metric register file: one write port, four registered read ports.
// Out-of-range addresses are ignored on write and read back as zero.
module multi_divi_llr_rf
  import multi_divi_pkg::*;
#(
  parameter int J       = 14,
  parameter int A       = 2,
  parameter int LW      = 16,
  parameter int J_WIDTH = calc_j_width(J),
  parameter int AWIDTH  = calc_a_width(A)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [J_WIDTH-1:0]        wr_row,
  input  logic [AWIDTH-1:0]         wr_col,
  input  logic signed [LW-1:0]      wr_data,
  input  logic [J_WIDTH-1:0]        rd_row [4],
  input  logic [AWIDTH-1:0]         rd_col [4],
  output logic signed [LW-1:0]      rd_data [4]
);

  logic signed [LW-1:0] mem    [J][A];
  logic signed [LW-1:0] rd_sel [4];

  // Full decode keeps out-of-range indices harmless without array bound checks
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_sel[p] = '0;
      for (int r = 0; r < J; r++) begin
        for (int c = 0; c < A; c++) begin
          if (int'(rd_row[p]) == r && int'(rd_col[p]) == c) begin
            rd_sel[p] = mem[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < J; r++) begin
        for (int c = 0; c < A; c++) begin
          mem[r][c] <= '0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        rd_data[p] <= '0;
      end
    end else begin
      for (int r = 0; r < J; r++) begin
        for (int c = 0; c < A; c++) begin
          if (wr_en && int'(wr_row) == r && int'(wr_col) == c) begin
            mem[r][c] <= wr_data;
          end
        end
      end
      for (int p = 0; p < 4; p++) begin
        rd_data[p] <= rd_sel[p];
      end
    end
  end

endmodule

// File: rtl/multi_divi_metric_eval.sv
// Log-domain candidate metric evaluator: base + L[mul] - L[div] per beat, best kept, reported after tlast.
// Define MULTI_DIVI_SAT_EN to saturate delta and final sums; otherwise they wrap at MW bits.
module multi_divi_metric_eval
  import multi_divi_pkg::*;
#(
  parameter int J       = 14,
  parameter int A       = 2,
  parameter int LW      = 16,
  parameter int MW      = 20,
  parameter int CW      = 16,
  parameter int J_WIDTH = calc_j_width(J),
  parameter int AWIDTH  = calc_a_width(A)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_wr_en,
  input  logic [J_WIDTH-1:0]     tbl_wr_row,
  input  logic [AWIDTH-1:0]      tbl_wr_col,
  input  logic signed [LW-1:0]   tbl_wr_data,
  input  logic                   eval_start,
  input  logic signed [MW-1:0]   base_metric,
  input  logic [J_WIDTH-1:0]     mul_row1,
  input  logic [J_WIDTH-1:0]     mul_row2,
  input  logic [AWIDTH-1:0]      mul_col1,
  input  logic [AWIDTH-1:0]      mul_col2,
  input  logic [J_WIDTH-1:0]     div_row1,
  input  logic [J_WIDTH-1:0]     div_row2,
  input  logic [AWIDTH-1:0]      div_col1,
  input  logic [AWIDTH-1:0]      div_col2,
  input  logic [1:0]             idx_state,
  input  logic                   idx_tvalid,
  input  logic                   idx_tlast,
  output logic                   busy,
  output logic                   result_valid,
  output logic signed [MW-1:0]   best_metric,
  output logic [J_WIDTH-1:0]     best_row1,
  output logic [J_WIDTH-1:0]     best_row2,
  output logic [AWIDTH-1:0]      best_col1,
  output logic [AWIDTH-1:0]      best_col2,
  output logic                   best_is_double,
  output logic [CW-1:0]          cand_count,
  output logic                   err_orphan
);

  localparam logic signed [MW-1:0] METRIC_MIN = MW'(metric_min(MW));

  eval_state_e state_q, state_d;
  logic        flush_q;
  logic        start_go;
  logic        beat_take;
  logic        beat_dbl;

  logic [J_WIDTH-1:0]    rd_row  [4];
  logic [AWIDTH-1:0]     rd_col  [4];
  logic signed [LW-1:0]  rd_data [4];

  logic                  s1_valid, s1_dbl;
  logic [J_WIDTH-1:0]    s1_row1, s1_row2;
  logic [AWIDTH-1:0]     s1_col1, s1_col2;

  logic                  s2_valid, s2_dbl;
  logic signed [MW-1:0]  s2_delta;
  logic [J_WIDTH-1:0]    s2_row1, s2_row2;
  logic [AWIDTH-1:0]     s2_col1, s2_col2;

  logic signed [MW-1:0]  base_q;
  logic signed [MW-1:0]  delta_next;
  logic signed [MW-1:0]  cand_metric;

  assign busy      = (state_q != EV_IDLE);
  assign beat_dbl  = (idx_state == ST_GEN2);
  assign beat_take = (state_q == EV_RUN) && idx_tvalid &&
                     ((idx_state == ST_GEN) || beat_dbl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EV_IDLE;
      flush_q      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= (state_q == EV_FLUSH) ? ~flush_q : 1'b0;
      result_valid <= (state_q == EV_DONE);
    end
  end

  // FLUSH lasts two cycles so the tlast beat has cleared S2 and S3 before DONE
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    case (state_q)
      EV_IDLE: begin
        if (eval_start) begin
          state_d  = EV_RUN;
          start_go = 1'b1;
        end
      end
      EV_RUN: begin
        if (idx_tvalid && idx_tlast) state_d = EV_FLUSH;
      end
      EV_FLUSH: begin
        if (flush_q) state_d = EV_DONE;
      end
      EV_DONE: state_d = EV_IDLE;
      default: state_d = EV_IDLE;
    endcase
  end

  always_comb begin
    rd_row[0] = mul_row1;  rd_col[0] = mul_col1;
    rd_row[1] = div_row1;  rd_col[1] = div_col1;
    rd_row[2] = mul_row2;  rd_col[2] = mul_col2;
    rd_row[3] = div_row2;  rd_col[3] = div_col2;
  end

  multi_divi_llr_rf #(
    .J       (J),
    .A       (A),
    .LW      (LW),
    .J_WIDTH (J_WIDTH),
    .AWIDTH  (AWIDTH)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tbl_wr_en && !busy),
    .wr_row  (tbl_wr_row),
    .wr_col  (tbl_wr_col),
    .wr_data (tbl_wr_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dbl   <= 1'b0;
      s1_row1  <= '0;
      s1_row2  <= '0;
      s1_col1  <= '0;
      s1_col2  <= '0;
    end else begin
      s1_valid <= beat_take;
      s1_dbl   <= beat_take && beat_dbl;
      s1_row1  <= mul_row1;
      s1_col1  <= mul_col1;
      s1_row2  <= beat_dbl ? mul_row2 : '0;
      s1_col2  <= beat_dbl ? mul_col2 : '0;
    end
  end

`ifdef MULTI_DIVI_SAT_EN
  localparam logic signed [MW+1:0] SAT_HI = (MW+2)'(metric_max(MW));
  localparam logic signed [MW+1:0] SAT_LO = (MW+2)'(metric_min(MW));

  function automatic logic signed [MW-1:0] fit(input logic signed [MW+1:0] v);
    if (v > SAT_HI) return SAT_HI[MW-1:0];
    else if (v < SAT_LO) return SAT_LO[MW-1:0];
    else return v[MW-1:0];
  endfunction

  logic signed [MW+1:0] delta_wide;
  logic signed [MW+1:0] sum_wide;

  // Two guard bits hold any sum of four LW-bit entries or base plus delta exactly
  always_comb begin
    delta_wide = (MW+2)'(rd_data[0]) - (MW+2)'(rd_data[1]);
    if (s1_dbl) delta_wide = delta_wide + (MW+2)'(rd_data[2]) - (MW+2)'(rd_data[3]);
    delta_next  = fit(delta_wide);
    sum_wide    = (MW+2)'(base_q) + (MW+2)'(s2_delta);
    cand_metric = fit(sum_wide);
  end
`else
  always_comb begin
    delta_next = MW'(rd_data[0]) - MW'(rd_data[1]);
    if (s1_dbl) delta_next = delta_next + MW'(rd_data[2]) - MW'(rd_data[3]);
    cand_metric = base_q + s2_delta;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_dbl   <= 1'b0;
      s2_delta <= '0;
      s2_row1  <= '0;
      s2_row2  <= '0;
      s2_col1  <= '0;
      s2_col2  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_dbl   <= s1_dbl;
      s2_delta <= delta_next;
      s2_row1  <= s1_row1;
      s2_row2  <= s1_row2;
      s2_col1  <= s1_col1;
      s2_col2  <= s1_col2;
    end
  end

  // Strict greater-than keeps the earliest candidate on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q         <= '0;
      best_metric    <= METRIC_MIN;
      best_row1      <= '0;
      best_row2      <= '0;
      best_col1      <= '0;
      best_col2      <= '0;
      best_is_double <= 1'b0;
      cand_count     <= '0;
      err_orphan     <= 1'b0;
    end else if (start_go) begin
      base_q         <= base_metric;
      best_metric    <= METRIC_MIN;
      best_row1      <= '0;
      best_row2      <= '0;
      best_col1      <= '0;
      best_col2      <= '0;
      best_is_double <= 1'b0;
      cand_count     <= '0;
      err_orphan     <= 1'b0;
    end else begin
      if (state_q == EV_IDLE && idx_tvalid) err_orphan <= 1'b1;
      if (s2_valid) begin
        if (cand_count != '1) cand_count <= cand_count + CW'(1);
        if (cand_metric > best_metric) begin
          best_metric    <= cand_metric;
          best_row1      <= s2_row1;
          best_row2      <= s2_row2;
          best_col1      <= s2_col1;
          best_col2      <= s2_col2;
          best_is_double <= s2_dbl;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_divi_metric_eval.sv
// Scoreboard bench for multi_divi_metric_eval: directed streams push expected results, a monitor checks them.
module tb_multi_divi_metric_eval;

  localparam int J  = 14;
  localparam int A  = 2;
  localparam int LW = 16;
  localparam int MW = 20;
  localparam int CW = 16;
  localparam int JW = 5;
  localparam int AW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tbl_wr_en;
  logic [JW-1:0]        tbl_wr_row;
  logic [AW-1:0]        tbl_wr_col;
  logic signed [LW-1:0] tbl_wr_data;
  logic                 eval_start;
  logic signed [MW-1:0] base_metric;
  logic [JW-1:0]        mul_row1, mul_row2, div_row1, div_row2;
  logic [AW-1:0]        mul_col1, mul_col2, div_col1, div_col2;
  logic [1:0]           idx_state;
  logic                 idx_tvalid, idx_tlast;
  logic                 busy, result_valid;
  logic signed [MW-1:0] best_metric;
  logic [JW-1:0]        best_row1, best_row2;
  logic [AW-1:0]        best_col1, best_col2;
  logic                 best_is_double;
  logic [CW-1:0]        cand_count;
  logic                 err_orphan;

  always #5 clk = ~clk;

  multi_divi_metric_eval #(.J(J), .A(A), .LW(LW), .MW(MW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_row(tbl_wr_row), .tbl_wr_col(tbl_wr_col), .tbl_wr_data(tbl_wr_data),
    .eval_start(eval_start), .base_metric(base_metric),
    .mul_row1(mul_row1), .mul_row2(mul_row2), .mul_col1(mul_col1), .mul_col2(mul_col2),
    .div_row1(div_row1), .div_row2(div_row2), .div_col1(div_col1), .div_col2(div_col2),
    .idx_state(idx_state), .idx_tvalid(idx_tvalid), .idx_tlast(idx_tlast),
    .busy(busy), .result_valid(result_valid), .best_metric(best_metric),
    .best_row1(best_row1), .best_row2(best_row2), .best_col1(best_col1), .best_col2(best_col2),
    .best_is_double(best_is_double), .cand_count(cand_count), .err_orphan(err_orphan)
  );

  typedef struct {
    int metric;
    int row1;
    int row2;
    int col1;
    int col2;
    int dbl;
    int cnt;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t next_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rv_count = 0;
  int   rv_before;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Result monitor: every result_valid pulse must match the oldest queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        rv_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", cyc, e.cyc);
          checkOutput("best_metric", best_metric, e.metric);
          checkOutput("best_row1", best_row1, e.row1);
          checkOutput("best_row2", best_row2, e.row2);
          checkOutput("best_col1", best_col1, e.col1);
          checkOutput("best_col2", best_col2, e.col2);
          checkOutput("best_is_double", best_is_double, e.dbl);
          checkOutput("cand_count", cand_count, e.cnt);
        end
      end
    end
  end

  task automatic idleInputs();
    tbl_wr_en = 0; tbl_wr_row = '0; tbl_wr_col = '0; tbl_wr_data = '0;
    eval_start = 0; base_metric = '0;
    mul_row1 = '0; mul_row2 = '0; div_row1 = '0; div_row2 = '0;
    mul_col1 = '0; mul_col2 = '0; div_col1 = '0; div_col2 = '0;
    idx_state = '0; idx_tvalid = 0; idx_tlast = 0;
  endtask

  task automatic writeTable(input int r, input int c, input int d);
    tbl_wr_en = 1; tbl_wr_row = JW'(r); tbl_wr_col = AW'(c); tbl_wr_data = LW'(d);
    @(negedge clk);
    tbl_wr_en = 0;
  endtask

  task automatic startEval(input int base);
    eval_start = 1; base_metric = MW'(base);
    @(negedge clk);
    eval_start = 0;
  endtask

  task automatic setExp(input int m, input int r1, input int r2, input int c1, input int c2,
                        input int d, input int n);
    next_exp.metric = m; next_exp.row1 = r1; next_exp.row2 = r2;
    next_exp.col1 = c1; next_exp.col2 = c2; next_exp.dbl = d; next_exp.cnt = n;
  endtask

  task automatic applyStimulus(input int st, input int mr1, input int mc1, input int dr1, input int dc1,
                               input int mr2, input int mc2, input int dr2, input int dc2,
                               input bit last, input bit valid);
    idx_state = 2'(st);
    mul_row1 = JW'(mr1); mul_col1 = AW'(mc1); div_row1 = JW'(dr1); div_col1 = AW'(dc1);
    mul_row2 = JW'(mr2); mul_col2 = AW'(mc2); div_row2 = JW'(dr2); div_col2 = AW'(dc2);
    idx_tvalid = valid; idx_tlast = last;
    if (last && valid) begin
      next_exp.cyc = cyc + 4;
      sb.push_back(next_exp);
    end
    @(negedge clk);
    idx_tvalid = 0; idx_tlast = 0;
  endtask

  task automatic waitResult();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("result_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1;
    idleInputs();
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_result_valid", result_valid, 0);
    checkOutput("reset_best_metric", best_metric, -524288);
    checkOutput("reset_cand_count", cand_count, 0);
    checkOutput("reset_err_orphan", err_orphan, 0);
    rst = 0;
    @(negedge clk);

    $display("[TB] orphan beat in IDLE");
    applyStimulus(2, 5, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("orphan_err", err_orphan, 1);
    checkOutput("orphan_cand_count", cand_count, 0);
    checkOutput("orphan_busy", busy, 0);

    for (int r = 0; r < J; r++) writeTable(r, 1, r);

    $display("[TB] single flip");
    startEval(100);
    checkOutput("start_clears_orphan", err_orphan, 0);
    checkOutput("start_busy", busy, 1);
    setExp(105, 5, 0, 1, 0, 0, 1);
    applyStimulus(2, 5, 1, 5, 0, 0, 0, 0, 0, 1, 1);
    waitResult();
    checkOutput("done_busy", busy, 0);

    $display("[TB] mixed single and double");
    startEval(100);
    applyStimulus(2, 5, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(3, 3, 1, 3, 0, 13, 1, 13, 0, 0, 1);
    setExp(116, 3, 13, 1, 1, 1, 3);
    applyStimulus(3, 1, 1, 1, 0, 2, 1, 2, 0, 1, 1);
    waitResult();

    $display("[TB] tie keeps earliest");
    writeTable(7, 1, 5);
    startEval(100);
    applyStimulus(2, 5, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    setExp(105, 5, 0, 1, 0, 0, 2);
    applyStimulus(2, 7, 1, 7, 0, 0, 0, 0, 0, 1, 1);
    waitResult();

    $display("[TB] protocol: ignored beats, start and write while busy");
    startEval(100);
    applyStimulus(1, 13, 1, 13, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(2, 13, 1, 13, 0, 0, 0, 0, 0, 0, 0);
    startEval(5000);
    writeTable(4, 1, 999);
    checkOutput("busy_mid_run", busy, 1);
    applyStimulus(2, 4, 1, 4, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(2, 15, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    setExp(104, 4, 0, 1, 0, 0, 2);
    applyStimulus(0, 13, 1, 13, 0, 0, 0, 0, 0, 1, 1);
    waitResult();

    $display("[TB] zero valid candidates");
    startEval(100);
    setExp(-524288, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 1, 9, 0, 0, 0, 0, 0, 1, 1);
    waitResult();

    $display("[TB] boundary overflow");
    writeTable(0, 1, 32767);
    writeTable(1, 1, 32767);
    startEval(484288);
`ifdef MULTI_DIVI_SAT_EN
    setExp(524287, 0, 1, 1, 1, 1, 1);
`else
    setExp(-498754, 0, 1, 1, 1, 1, 1);
`endif
    applyStimulus(3, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1);
    waitResult();

    $display("[TB] reset mid-stream");
    startEval(100);
    applyStimulus(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(2, 3, 1, 3, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(2, 4, 1, 4, 0, 0, 0, 0, 0, 0, 1);
    rst = 1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_best_metric", best_metric, -524288);
    checkOutput("abort_cand_count", cand_count, 0);
    @(negedge clk);
    rst = 0;
    rv_before = rv_count;
    repeat (8) @(negedge clk);
    checkOutput("abort_no_result", rv_count, rv_before);
    checkOutput("abort_result_valid", result_valid, 0);

    startEval(100);
    setExp(100, 5, 0, 1, 0, 0, 1);
    applyStimulus(2, 5, 1, 5, 0, 0, 0, 0, 0, 1, 1);
    waitResult();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
